// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one full-adder step per clock
module serial_adder #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ov
);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_a, r_b, r_sum;
  logic [N-2:0] r_res;
  logic [KW-1:0] r_k;
  logic r_c, r_co, r_ov;
  logic w_s, w_cout, w_last, w_accept;
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last   = r_k == KW'(N - 1);
  assign w_accept = start && r_state != RUN;
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign co   = r_co;
  assign ov   = r_ov;
  // next state: IDLE and DONE both accept a start; RUN leaves after the N-th bit
  always_comb begin
    w_next = IDLE;
    w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // operand load, one full-adder step per RUN edge, result capture on the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_k   <= '0;
      r_res <= '0;
      r_sum <= '0;
      r_co  <= 1'b0;
      r_ov  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= inp1;
      r_b   <= inp2;
      r_c   <= cin;
      r_k   <= '0;
      r_res <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cout;
      r_k   <= r_k + KW'(1);
      r_res <= (r_res >> 1) | ((N-1)'(w_s) << (N - 2));
      if (w_last) begin
        r_sum <= {w_s, r_res};
        r_co  <= w_cout;
        r_ov  <= r_c ^ w_cout;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with hand-computed sums for serial_adder
module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] inp1 = '0;
  logic [15:0] inp2 = '0;
  logic        cin = 1'b0;
  logic        busy, done, co, ov;
  logic [15:0] sum;
  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inp1(inp1), .inp2(inp2), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .co(co), .ov(ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic eco, input logic eov);
    int nb;
    int cyc;
    nb = 0;
    cyc = 0;
    @(negedge clk);
    inp1 = a; inp2 = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    inp1 = ~a;
    while (cyc < 40) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      cyc++;
    end
    check({tag, "_busy_cycles"}, nb, 16);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_co"}, co, eco);
    check({tag, "_ov"}, ov, eov);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int dn;
    int t1, t2;
    logic [15:0] s1, s2;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_co_ov", {co, ov}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ucarry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("sovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // start during RUN with different operands must be ignored
    @(negedge clk);
    inp1 = 16'h1234; inp2 = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    inp1 = 16'hFFFF; inp2 = 16'hFFFF; cin = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("ign_sum_held", sum, 16'h0000);
    check("ign_busy", busy, 1);
    dn = 0; s1 = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin dn++; s1 = sum; end
    end
    check("ign_done_count", dn, 1);
    check("ign_sum", s1, 16'h5555);

    // back-to-back with start held high
    @(negedge clk);
    inp1 = 16'h0001; inp2 = 16'h0002; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    inp1 = 16'h00FF; inp2 = 16'h0001;
    t1 = -1; t2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        if (t1 < 0) begin t1 = i; s1 = sum; end
        else begin t2 = i; s2 = sum; start = 1'b0; break; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_sum1", s1, 16'h0003);
    check("b2b_sum2", s2, 16'h0100);
    check("b2b_gap", t2 - t1, 17);
    repeat (20) @(negedge clk);
    check("b2b_idle", busy, 0);

    // asynchronous reset five cycles into RUN
    inp1 = 16'hAAAA; inp2 = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rmid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_sum", sum, 0);
    check("rmid_co_ov", {co, ov}, 0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("rmid_no_done", dn, 0);
    run_op("after_rst", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder for the CPU datapath: the addition counterpart to the existing ripple-borrow subtractor. It latches two operands and a carry-in on a start request and resolves the sum LSB-first, one bit per clock, through a single registered full-adder cell. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It trades latency for area and is used where a full-width combinational adder is not justified.

## Interface
- N, default 16, operand and sum width in bits; N ≥ 2.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request an addition; accepted only on an edge where busy=0.
- inp1  in  N  addend A; sampled only on the accepting edge.
- inp2  in  N  addend B; sampled only on the accepting edge.
- cin  in  1  carry-in; sampled only on the accepting edge.
- busy  out  1  high while an addition is in progress (RUN state).
- done  out  1  one-cycle pulse: sum, co and ov were updated on the previous edge.
- sum  out  N  registered result A+B+cin (mod 2^N); held between completions.
- co  out  1  registered carry out of bit N-1.
- ov  out  1  registered signed overflow = carry into bit N-1 XOR carry out of bit N-1.

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE. busy=0, done=0, sum=0, co=0, ov=0. Shift registers, carry flop and bit counter all cleared.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- IDLE→RUN on start=1. On that edge:
  - inp1 and inp2 load into internal shift registers a and b.
  - cin loads the carry flop c.
  - Bit counter k is set to 0.
  - The result shift register is cleared.
- RUN, every edge:
  - s = a[0]^b[0]^c; the carry flop takes c ← maj(a[0], b[0], c).
  - s shifts into the result register MSB-first, so after N shifts bit i sits at position i.
  - a and b shift right by 1; k increments.
  - On the edge where k=N-1 (the N-th RUN edge):
    - Load sum from the completed result.
    - co = carry out of the final bit.
    - ov = c XOR co, where c is the carry value entering that bit.
    - Go to DONE.
- DONE, next edge: start=1 goes to RUN (new operands accepted, same load as from IDLE); otherwise go to IDLE.
- start while busy=1 is ignored. It is neither queued nor does it disturb the operation in progress.
- Changes on inp1, inp2 and cin after the accepting edge have no effect on the operation in progress.
- sum, co and ov change only on the completing edge (or on reset). They hold their previous values throughout RUN.
- k is ceil(log2(N)) bits wide and never wraps within an operation.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced. sum, co and ov go to 0.

## Timing
- Latency: with start accepted on edge E0, RUN spans edges E1..EN, and done is high for the cycle after EN. That is N cycles from the accepting edge to sum valid and done=1.
- busy rises after E0 and falls after EN. busy is high for exactly N cycles.
- done is high for exactly one cycle per completed operation.
- Throughput: start held high continuously gives one result every N+1 cycles (E0, N RUN edges, and one DONE edge that re-accepts).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic add: reset, then N=16, start with inp1=0x1234, inp2=0x4321, cin=0 → busy high for 16 cycles, then done pulse with sum=0x5555, co=0, ov=0.
- Unsigned carry: inp1=0xFFFF, inp2=0x0001, cin=0 → sum=0x0000, co=1, ov=0. Then inp1=0x0000, inp2=0x0000, cin=1 → sum=0x0001, co=0, ov=0.
- Signed overflow: 0x7FFF+0x0001 → sum=0x8000, co=0, ov=1. Then 0x8000+0x8000 → sum=0x0000, co=1, ov=1.
- Ignored start and operand hold:
  - Assert start with new operands mid-RUN → no effect; the first result completes unchanged and done pulses once.
  - Change inp1 after the accepting edge → result still reflects the latched value.
- Back-to-back: hold start=1 with 0x0001+0x0002, then 0x00FF+0x0001 → done pulses 17 cycles apart; sums 0x0003 then 0x0100.
- Reset mid-operation: drop rst_n 5 cycles into RUN of 0xAAAA+0x5555 → busy, done, sum, co and ov all 0 immediately, asynchronously to clk. No done follows. After release, a fresh 0xAAAA+0x5555 gives sum=0xFFFF, co=0, ov=0.
